// File: rtl/md_wb_arb.sv
// md_wb_arb: merges multiplier results (via a 2-entry queue) with non-MD register writebacks.
// Define MD_WB_FWD_EN to build forwarding from queued entries to the decode-stage sources.
module md_wb_arb (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        mul2mem_prod_complete_ffout,
    input  logic        mul2mem_HI_ffout,
    input  logic        mul2mem_LO_ffout,
    input  logic [31:0] multprod_HI_ffout,
    input  logic [31:0] multprod_LO_ffout,
    input  logic [4:0]  mul_rdaddr,
    input  logic        mul_fuse,
    input  logic [4:0]  mul_fuse_rdaddr,
    input  logic        ex2mem_wr_valid,
    input  logic [4:0]  ex2mem_wr_regindex,
    input  logic [31:0] ex2mem_wr_data,
    input  logic [4:0]  de_rs1addr,
    input  logic [4:0]  de_rs2addr,
    output logic        mem2wb_wr_en,
    output logic [4:0]  mem2wb_wr_regindex,
    output logic [31:0] mem2wb_wr_data,
    output logic        md_wb_stall,
    output logic        md_ovf,
    output logic        md_fwd_hit_rs1,
    output logic        md_fwd_hit_rs2,
    output logic [31:0] md_fwd_data_rs1,
    output logic [31:0] md_fwd_data_rs2
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;

    occ_t             state_q, state_d;
    logic [1:0][4:0]  idx_q, idx_d;
    logic [1:0][31:0] dat_q, dat_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_idx_q, wr_idx_d;
    logic [31:0]      wr_dat_q, wr_dat_d;
    logic             ovf_q, ovf_d;

    logic             nonempty, wr_vld, skip_first;
    logic [4:0]       new_idx0, new_idx1;
    logic [31:0]      new_dat0, new_dat1;
    logic [1:0]       occ;

    // The HI flag alone selects the half for a non-fused completion.
    logic unused_lo_sel;
    assign unused_lo_sel = mul2mem_LO_ffout;

    assign nonempty    = (state_q != EMPTY);
    assign md_wb_stall = ex2mem_wr_valid & (nonempty | mul2mem_prod_complete_ffout);

    always_comb begin
        new_idx0 = mul_rdaddr;
        new_dat0 = (mul_fuse || mul2mem_HI_ffout) ? multprod_HI_ffout : multprod_LO_ffout;
        new_idx1 = mul_fuse_rdaddr;
        new_dat1 = multprod_LO_ffout;

        wr_vld     = 1'b0;
        wr_idx_d   = '0;
        wr_dat_d   = '0;
        skip_first = 1'b0;
        if (nonempty) begin
            wr_vld   = 1'b1;
            wr_idx_d = idx_q[0];
            wr_dat_d = dat_q[0];
        end else if (mul2mem_prod_complete_ffout) begin
            wr_vld     = 1'b1;
            wr_idx_d   = new_idx0;
            wr_dat_d   = new_dat0;
            skip_first = 1'b1;
        end else if (ex2mem_wr_valid) begin
            wr_vld   = 1'b1;
            wr_idx_d = ex2mem_wr_regindex;
            wr_dat_d = ex2mem_wr_data;
        end
        wr_en_d = wr_vld && (wr_idx_d != '0);

        // Dequeue (shift slot 1 down) happens before any new entry is appended.
        idx_d = idx_q;
        dat_d = dat_q;
        ovf_d = ovf_q;
        occ   = 2'd0;
        if (state_q == TWO) begin
            idx_d[0] = idx_q[1];
            dat_d[0] = dat_q[1];
            occ      = 2'd1;
        end
        if (mul2mem_prod_complete_ffout && !skip_first) begin
            if (occ == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                idx_d[occ[0]] = new_idx0;
                dat_d[occ[0]] = new_dat0;
                occ           = occ + 2'd1;
            end
        end
        if (mul2mem_prod_complete_ffout && mul_fuse) begin
            if (occ == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                idx_d[occ[0]] = new_idx1;
                dat_d[occ[0]] = new_dat1;
                occ           = occ + 2'd1;
            end
        end
        case (occ)
            2'd0:    state_d = EMPTY;
            2'd1:    state_d = ONE;
            default: state_d = TWO;
        endcase
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_q  <= EMPTY;
            idx_q    <= '0;
            dat_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            wr_dat_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dat_q    <= dat_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            wr_dat_q <= wr_dat_d;
            ovf_q    <= ovf_d;
        end
    end

    assign mem2wb_wr_en       = wr_en_q;
    assign mem2wb_wr_regindex = wr_idx_q;
    assign mem2wb_wr_data     = wr_dat_q;
    assign md_ovf             = ovf_q;

`ifdef MD_WB_FWD_EN
    // Slot 1 is younger than slot 0, so it wins when both match.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] rs, input occ_t st,
                                               input logic [1:0][4:0] idx,
                                               input logic [1:0][31:0] dat);
        logic [32:0] r;
        r = '0;
        if (rs != '0) begin
            if (st == TWO && idx[1] == rs)
                r = {1'b1, dat[1]};
            else if (st != EMPTY && idx[0] == rs)
                r = {1'b1, dat[0]};
        end
        return r;
    endfunction

    always_comb begin
        {md_fwd_hit_rs1, md_fwd_data_rs1} = fwd_lookup(de_rs1addr, state_q, idx_q, dat_q);
        {md_fwd_hit_rs2, md_fwd_data_rs2} = fwd_lookup(de_rs2addr, state_q, idx_q, dat_q);
    end
`else
    logic unused_de;
    assign unused_de       = ^{de_rs1addr, de_rs2addr};
    assign md_fwd_hit_rs1  = 1'b0;
    assign md_fwd_hit_rs2  = 1'b0;
    assign md_fwd_data_rs1 = '0;
    assign md_fwd_data_rs2 = '0;
`endif

endmodule
